alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 187 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe -- valid/ready ALU with a single-cycle datapath for most opcodes
// and an iterative shift-add multiplier (one multiplier bit per cycle).
//
// Ports
//   clk        clock, rising-edge active
//   rst        asynchronous active-high reset
//   in_valid   operands/opcode presented
//   in_ready   block accepts operands this cycle
//   I          4-bit opcode
//   A, B       WIDTH-bit operands
//   out_valid  Result/flags/err valid
//   out_ready  consumer takes the result this cycle
//   Result     WIDTH-bit result
//   flags      {N, Z, C, V}
//   err        accepted opcode was reserved
// ---------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       I,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       flags,
    output logic             err
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SRL  = 4'd3;
    localparam logic [3:0] OP_SRA  = 4'd4;
    localparam logic [3:0] OP_SLT  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_MUL  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_XNOR = 4'd11;

    localparam logic [SHW-1:0] MUL_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        HOLD
    } state_t;

    state_t state, state_next;

    // Multiplier working registers: shifted multiplicand, shifted multiplier,
    // running partial product and step counter.
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [SHW-1:0]   cnt;

    logic             accept, accept_mul, accept_alu, out_xfer, mul_last;
    logic [WIDTH-1:0] mul_next;

    logic [WIDTH:0]   sum_ext, diff_ext;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_err;
    logic [3:0]       alu_flags;

    // Ready only depends on state and the output slot, never on in_valid.
    assign in_ready   = (state == IDLE) && (!out_valid || out_ready);
    assign accept     = in_valid && in_ready;
    assign accept_mul = accept && (I == OP_MUL);
    assign accept_alu = accept && (I != OP_MUL);
    assign out_xfer   = out_valid && out_ready;
    assign mul_last   = (state == MUL) && (cnt == MUL_LAST);
    assign mul_next   = acc + (mplier[0] ? mcand : '0);

    assign sum_ext  = {1'b0, A} + {1'b0, B};
    assign diff_ext = {1'b0, A} - {1'b0, B};
    assign shamt    = B[SHW-1:0];

    // Single-cycle datapath. MUL is handled by the iterative unit below.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (I)
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];  // borrow, i.e. A < B unsigned
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(A) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_MUL:  alu_res = '0;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_XNOR: alu_res = ~(A ^ B);
            default: alu_err = 1'b1;   // reserved: zero result, Z set by flags
        endcase
    end

    assign alu_flags = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_mul) state_next = MUL;
            MUL:     if (mul_last)   state_next = HOLD;
            HOLD:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output register and multiplier datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            Result    <= '0;
            flags     <= '0;
            err       <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            // A new single-cycle op may replace a result leaving this cycle;
            // otherwise a completed transfer empties the output slot.
            if (accept_alu) begin
                Result    <= alu_res;
                flags     <= alu_flags;
                err       <= alu_err;
                out_valid <= 1'b1;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end

            if (accept_mul) begin
                mcand  <= A;
                mplier <= B;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == MUL) begin
                acc    <= mul_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + SHW'(1);
                if (mul_last) begin
                    Result    <= mul_next;
                    flags     <= {mul_next[WIDTH-1], (mul_next == '0), 2'b00};
                    err       <= 1'b0;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH = 32).
// A negedge monitor pushes the expected record for every accepted operation
// into a scoreboard queue and pops/compares it on every output transfer.
// ---------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    I;
    logic [W-1:0]  A, B;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  Result;
    logic [3:0]    flags;
    logic          err;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .I         (I),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Result    (Result),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         er;
    } exp_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   flg;
        logic         er;
    } vec_t;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     n_push = 0;
    int     n_pop = 0;
    int     n_discard = 0;
    exp_t   sb[$];
    int     out_cyc[$];
    exp_t   mon_e;

    logic [W-1:0] drv_res;
    logic [3:0]   drv_flg;
    logic         drv_er;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: handshakes are evaluated at the negedge, where all
    // DUT outputs and bench inputs are settled.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                out_cyc.push_back(cyc);
                n_pop++;
                if (sb.size() == 0) begin
                    check("spurious_output", 64'(Result), 64'hDEAD_0000_0000);
                end else begin
                    mon_e = sb.pop_front();
                    check("sb_result", 64'(Result), 64'(mon_e.res));
                    check("sb_flags",  64'(flags),  64'(mon_e.flg));
                    check("sb_err",    64'(err),    64'(mon_e.er));
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(exp_t'{drv_res, drv_flg, drv_er});
                n_push++;
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er_res, input logic [3:0] er_flg, input logic er_err,
                        output int acc_cyc);
        bit done = 0;
        I = op; A = a; B = b;
        drv_res = er_res; drv_flg = er_flg; drv_er = er_err;
        in_valid = 1'b1;
        acc_cyc = -1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
                done = 1;
            end
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_empty();
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            if (sb.size() == 0 && !out_valid) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check("drain_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [3:0] nz(input logic [W-1:0] r);
        return {r[W-1], (r == '0), 2'b00};
    endfunction

    vec_t vecs[18];
    int   acc_c;
    int   acc_list[$];
    int   hi_cnt;
    logic [W-1:0] xa, xb, xr, held;

    initial begin
        vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0110, 1'b0};
        vecs[1]  = '{4'd1,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001, 1'b0};
        vecs[2]  = '{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 4'b0000, 1'b0};
        vecs[3]  = '{4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0100, 1'b0};
        vecs[4]  = '{4'd4,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 4'b1000, 1'b0};
        vecs[5]  = '{4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b1001, 1'b0};
        vecs[6]  = '{4'd1,  32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 4'b1010, 1'b0};
        vecs[7]  = '{4'd2,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 4'b0000, 1'b0};
        vecs[8]  = '{4'd3,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000, 1'b0};
        vecs[9]  = '{4'd8,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000, 1'b0};
        vecs[10] = '{4'd9,  32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100, 1'b0};
        vecs[11] = '{4'd10, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 4'b1000, 1'b0};
        vecs[12] = '{4'd11, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 4'b1000, 1'b0};
        vecs[13] = '{4'd13, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000, 4'b0100, 1'b1};
        vecs[14] = '{4'd0,  32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000, 1'b0};
        vecs[15] = '{4'd1,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0100, 1'b0};
        vecs[16] = '{4'd5,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100, 1'b0};
        vecs[17] = '{4'd15, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b0100, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        I = '0; A = '0; B = '0;
        drv_res = '0; drv_flg = '0; drv_er = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result",    64'(Result),    64'd0);
        check("rst_flags",     64'(flags),     64'd0);
        check("rst_err",       64'(err),       64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        // First vector must be taken on the first rising edge after release.
        send(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].res, vecs[0].flg, vecs[0].er, acc_c);
        check("first_accept_cycle", 64'(acc_c), 64'(cyc - 1));

        // Table-driven single-cycle ops, back to back.
        for (int i = 1; i < 18; i++)
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flg, vecs[i].er, acc_c);
        wait_empty();

        // MUL latency and hold under back-pressure.
        out_ready = 1'b0;
        send(4'd7, 32'h0001_2345, 32'h0000_0010, 32'h0012_3450, 4'b0000, 1'b0, acc_c);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            check($sformatf("mul_in_ready_c%0d", k), 64'(in_ready), 64'd0);
            check($sformatf("mul_out_valid_c%0d", k), 64'(out_valid), 64'(k == 33));
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("mul_hold_valid",  64'(out_valid), 64'd1);
            check("mul_hold_result", 64'(Result),    64'h0012_3450);
            check("mul_hold_ready",  64'(in_ready),  64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);   // monitor takes the result here
        @(negedge clk);
        check("mul_after_valid", 64'(out_valid), 64'd0);
        check("mul_after_ready", 64'(in_ready),  64'd1);
        @(posedge clk);
        #1;

        // Ten back-to-back XORs at full throughput.
        out_cyc.delete();
        acc_list.delete();
        for (int i = 0; i < 10; i++) begin
            xa = 32'h0101_0101 * (i + 1);
            xb = 32'h0F0F_00FF ^ (32'h1 << i);
            xr = xa ^ xb;
            send(4'd10, xa, xb, xr, nz(xr), 1'b0, acc_c);
            acc_list.push_back(acc_c);
        end
        wait_empty();
        check("xor_out_count", 64'(out_cyc.size()), 64'd10);
        for (int i = 1; i < 10; i++) begin
            if (i < acc_list.size())
                check("xor_accept_consecutive", 64'(acc_list[i]), 64'(acc_list[0] + i));
            if (i < out_cyc.size())
                check("xor_out_consecutive", 64'(out_cyc[i]), 64'(out_cyc[0] + i));
        end

        // Back-pressure on a single-cycle op: one result pending blocks input.
        out_ready = 1'b0;
        send(4'd10, 32'h0000_FFFF, 32'h00FF_00FF, 32'h00FF_FF00, 4'b0000, 1'b0, acc_c);
        fork
            send(4'd11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100, 1'b0, acc_c);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_in_ready",  64'(in_ready),  64'd0);
                    check("bp_out_valid", 64'(out_valid), 64'd1);
                    check("bp_result",    64'(Result),    64'h00FF_FF00);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_empty();

        // Reset pulsed in the middle of a multiply.
        send(4'd7, 32'h0000_0007, 32'h0000_0009, 32'h0000_003F, 4'b0000, 1'b0, acc_c);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        n_discard += sb.size();
        sb.delete();
        #4;
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        hi_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) hi_cnt++;
        end
        check("midrst_no_stale", 64'(hi_cnt), 64'd0);
        @(posedge clk);
        #1;
        send(4'd0, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 4'b0000, 1'b0, acc_c);
        wait_empty();

        check("sb_empty",   64'(sb.size()), 64'd0);
        check("sb_balance", 64'(n_push),    64'(n_pop + n_discard));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
